// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, variable-latency imem req/ack handshake and IF/ID register.
// Optional macro BRANCH_DELAY_SLOT_EN keeps the word fetched at the redirect point instead of flushing it.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        shouldStall,
    input  logic        shouldJumpOrBranch,
    input  logic [31:0] jumpOrBranchPc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_4,
    output logic [31:0] instruction,
    output logic        id_valid,
    output logic        fetch_busy
);

    typedef enum logic [1:0] {
        StReq   = 2'd0,
        StHold  = 2'd1,
        StDrain = 2'd2
    } state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] tgt_q;
    logic [31:0] buf_q;
    logic [31:0] pc_4_q;
    logic [31:0] instr_q;
    logic        valid_q;
`ifdef BRANCH_DELAY_SLOT_EN
    logic        pend_q;
`endif

    logic        adv;
    logic        redir;
    logic [31:0] pc_plus4;

    assign adv      = !shouldStall;
    assign redir    = adv & shouldJumpOrBranch;
    assign pc_plus4 = pc_q + 32'd4;

    // Request drops combinationally during reset so imem aborts any outstanding fetch.
    assign imem_req    = rst & (state_q != StHold);
    assign imem_addr   = pc_q;
    assign fetch_busy  = imem_req & !imem_ack;
    assign pc_4        = pc_4_q;
    assign instruction = instr_q;
    assign id_valid    = valid_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StReq;
            pc_q    <= RESET_PC;
            tgt_q   <= 32'h0;
            buf_q   <= 32'h0;
            pc_4_q  <= 32'h0;
            instr_q <= NOP_WORD;
            valid_q <= 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
            pend_q  <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StReq: begin
                    if (imem_ack) begin
                        if (redir) begin
`ifdef BRANCH_DELAY_SLOT_EN
                            pc_4_q  <= pc_plus4;
                            instr_q <= imem_rdata;
                            valid_q <= 1'b1;
`else
                            pc_4_q  <= 32'h0;
                            instr_q <= NOP_WORD;
                            valid_q <= 1'b0;
`endif
                            pc_q    <= jumpOrBranchPc;
                        end else if (!adv) begin
                            buf_q   <= imem_rdata;
                            state_q <= StHold;
                        end else begin
                            pc_4_q  <= pc_plus4;
                            instr_q <= imem_rdata;
                            valid_q <= 1'b1;
                            pc_q    <= pc_plus4;
                        end
                    end else if (redir) begin
                        tgt_q   <= jumpOrBranchPc;
                        pc_4_q  <= 32'h0;
                        instr_q <= NOP_WORD;
                        valid_q <= 1'b0;
                        state_q <= StDrain;
                    end else if (adv) begin
                        pc_4_q  <= 32'h0;
                        instr_q <= NOP_WORD;
                        valid_q <= 1'b0;
                    end
                end

                StHold: begin
                    if (adv) begin
`ifdef BRANCH_DELAY_SLOT_EN
                        pc_4_q  <= pc_plus4;
                        instr_q <= buf_q;
                        valid_q <= 1'b1;
                        pc_q    <= redir ? jumpOrBranchPc : (pend_q ? tgt_q : pc_plus4);
                        pend_q  <= 1'b0;
`else
                        if (redir) begin
                            pc_4_q  <= 32'h0;
                            instr_q <= NOP_WORD;
                            valid_q <= 1'b0;
                            pc_q    <= jumpOrBranchPc;
                        end else begin
                            pc_4_q  <= pc_plus4;
                            instr_q <= buf_q;
                            valid_q <= 1'b1;
                            pc_q    <= pc_plus4;
                        end
`endif
                        state_q <= StReq;
                    end
                end

                StDrain: begin
                    if (imem_ack) begin
`ifdef BRANCH_DELAY_SLOT_EN
                        if (adv) begin
                            pc_4_q  <= pc_plus4;
                            instr_q <= imem_rdata;
                            valid_q <= 1'b1;
                            pc_q    <= redir ? jumpOrBranchPc : tgt_q;
                            state_q <= StReq;
                        end else begin
                            buf_q   <= imem_rdata;
                            pend_q  <= 1'b1;
                            state_q <= StHold;
                        end
`else
                        // A redirect arriving with the ack is newer than tgt_q, so it wins.
                        pc_q    <= redir ? jumpOrBranchPc : tgt_q;
                        state_q <= StReq;
                        if (adv) begin
                            pc_4_q  <= 32'h0;
                            instr_q <= NOP_WORD;
                            valid_q <= 1'b0;
                        end
`endif
                    end else begin
                        if (redir) begin
                            tgt_q <= jumpOrBranchPc;
                        end
                        if (adv) begin
                            pc_4_q  <= 32'h0;
                            instr_q <= NOP_WORD;
                            valid_q <= 1'b0;
                        end
                    end
                end

                default: state_q <= StReq;
            endcase
        end
    end

endmodule
